// File: rtl/decrement_circuit_seq.sv
// Multi-cycle decrement of a WIDTH-bit operand, one 4-bit slice per cycle,
// with a borrow chain that can terminate early once the running borrow clears.
module decrement_circuit_seq #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic             bin,
  input  logic             bprev,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             borrow
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  // PREP is the one-cycle load stage between accept and the first slice,
  // so DONE is entered 1+m edges after the accepting edge.
  typedef enum logic [1:0] {IDLE, PREP, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] op_q, op_new;
  logic [IW-1:0]    idx;
  logic             b, bprev_q;
  logic [3:0]       slice, res_slice;
  logic             b_next, finish;

  always_comb begin
    slice     = op_q[{idx, 2'b00} +: 4];
    res_slice = slice - {3'b000, b};
    b_next    = b & (slice == 4'h0);
    finish    = (idx == LAST) || (EARLY_EXIT && !b_next);
    op_new    = op_q;
    op_new[{idx, 2'b00} +: 4] = res_slice;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (in_valid)  state_next = PREP;
      PREP:                state_next = RUN;
      RUN:  if (finish)    state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      idx     <= '0;
      b       <= 1'b0;
      bprev_q <= 1'b0;
      result  <= '0;
      borrow  <= 1'b0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_q    <= operand;
            b       <= bin;
            bprev_q <= bprev;
            idx     <= '0;
          end
        end
        RUN: begin
          op_q <= op_new;
          b    <= b_next;
          if (finish) begin
            // Untouched upper slices of op_new already hold the operand bits.
            result <= op_new;
            borrow <= bprev_q | b_next;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
